// File: rtl/dest_pkg.sv
// Shared constants and types for the destination encoder/decoder pair.
package dest_pkg;
  localparam int N_SRC = 16;
  localparam int IDX_W = 4;

  typedef logic [IDX_W-1:0] src_idx_t;
  typedef logic [N_SRC-1:0] src_vec_t;
endpackage

// File: rtl/dest_encoder_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of i_vector at or
// above i_ptr, wrapping from N-1 back to 0.
module rr_pick
  import dest_pkg::*;
#(
  parameter int N = N_SRC,
  parameter int W = IDX_W
) (
  input  logic [N-1:0] i_vector,
  input  logic [W-1:0] i_ptr,
  output logic         o_any,
  output logic [W-1:0] o_index,
  output logic [N-1:0] o_onehot
);
  localparam logic [W:0] L_N = (W+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_lo;
  logic [W:0]     w_sum;

  // Rotate so that bit i_ptr lands at position 0, then the lowest set bit wins.
  assign w_dbl = {i_vector, i_vector} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];
  assign o_any = |i_vector;

  always_comb begin
    w_lo = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (w_rot[i]) w_lo = W'(i);
    end
    w_sum = {1'b0, w_lo} + {1'b0, i_ptr};
    if (w_sum >= L_N) w_sum = w_sum - L_N;
  end

  assign o_index  = w_sum[W-1:0];
  assign o_onehot = o_any ? (N'(1) << o_index) : '0;
endmodule

// File: rtl/dest_encoder.sv
// Collects one-hot request pulses into a pending set and grants them one at a
// time, round-robin, as a source index over a registered valid/ready stage.
module dest_encoder
  import dest_pkg::*;
#(
  parameter int N = N_SRC,
  parameter int W = IDX_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [W-1:0] src,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending,
  output logic         overflow
);
  logic [N-1:0] r_pending;
  logic [W-1:0] r_src;
  logic         r_valid;
  logic [W-1:0] r_ptr;
  logic         r_overflow;

  logic         w_any;
  logic [W-1:0] w_idx;
  logic [N-1:0] w_onehot;
  logic         w_load;
  logic [N-1:0] w_take;

  rr_pick #(.N(N), .W(W)) u_pick (
    .i_vector (r_pending),
    .i_ptr    (r_ptr),
    .o_any    (w_any),
    .o_index  (w_idx),
    .o_onehot (w_onehot)
  );

  // Selection only ever looks at registered pending, never same-cycle req.
  assign w_load = (!r_valid || ready) && w_any;
  assign w_take = w_load ? w_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_src      <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_overflow <= 1'b0;
    end else begin
      // A re-request on the bit being taken survives as a fresh pending entry.
      r_pending  <= (r_pending & ~w_take) | req;
      r_overflow <= |(req & r_pending & ~w_take);
      if (w_load) begin
        r_src   <= w_idx;
        r_valid <= 1'b1;
        r_ptr   <= (w_idx == W'(N-1)) ? '0 : w_idx + 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign src      = r_src;
  assign valid    = r_valid;
  assign pending  = r_pending;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_dest_encoder.sv
// Randomized and directed checks of dest_encoder against a pending-set model.
module tb_dest_encoder;
  import dest_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  src_vec_t req = '0;
  logic     ready = 1'b0;
  src_idx_t src;
  logic     valid;
  src_vec_t pending;
  logic     overflow;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: set of waiting sources, the held grant, and the next-search start.
  bit m_pend [N_SRC];
  bit m_valid;
  int m_src;
  int m_ptr;
  bit m_ovf;

  dest_encoder #(.N(N_SRC), .W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .src      (src),
    .valid    (valid),
    .ready    (ready),
    .pending  (pending),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_pend_vec();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < N_SRC; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N_SRC; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_src   = 0;
    m_ptr   = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic m_step(input logic [15:0] rq, input bit rdy);
    bit any;
    int take;
    any  = 1'b0;
    take = -1;
    for (int i = 0; i < N_SRC; i++) any |= m_pend[i];
    if ((!m_valid || rdy) && any) begin
      for (int k = N_SRC-1; k >= 0; k--)
        if (m_pend[(m_ptr + k) % N_SRC]) take = (m_ptr + k) % N_SRC;
      m_src   = take;
      m_valid = 1'b1;
      m_ptr   = (take + 1) % N_SRC;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ovf = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (rq[i] && m_pend[i] && i != take) m_ovf = 1'b1;
      m_pend[i] = (m_pend[i] && i != take) || rq[i];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_pending",  32'(pending),  32'(m_pend_vec()));
      chk("cyc_valid",    32'(valid),    32'(m_valid));
      chk("cyc_src",      32'(src),      32'(m_src));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic tick(input logic [15:0] rq, input bit rdy);
    req   = rq;
    ready = rdy;
    @(posedge clk);
    m_step(rq, rdy);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_pending",  32'(pending),  32'h0);
    chk("rst_valid",    32'(valid),    32'h0);
    chk("rst_src",      32'(src),      32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    req   = '0;
    ready = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    m_step(16'h0, 1'b0);
    #1;
  endtask

  initial begin
    m_reset();
    #12;
    chk_en = 1'b1;
    do_reset();

    // Single request: src=5 for exactly one cycle.
    tick(16'h0020, 1'b1);
    chk("single_pend", 32'(pending), 32'h0020);
    chk("single_vld0", 32'(valid), 32'h0);
    tick(16'h0000, 1'b1);
    chk("single_vld1", 32'(valid), 32'h1);
    chk("single_src",  32'(src), 32'h5);
    chk("single_pend0", 32'(pending), 32'h0);
    tick(16'h0000, 1'b1);
    chk("single_drain", 32'(valid), 32'h0);

    // Round-robin wrap from ptr=0.
    do_reset();
    tick(16'h8001, 1'b0);
    tick(16'h0000, 1'b0);
    chk("wrap_src0", 32'(src), 32'h0);
    tick(16'h0001, 1'b1);
    chk("wrap_src15", 32'(src), 32'hF);
    chk("wrap_vld15", 32'(valid), 32'h1);
    tick(16'h0000, 1'b1);
    chk("wrap_src0b", 32'(src), 32'h0);
    tick(16'h0000, 1'b1);
    chk("wrap_drain", 32'(valid), 32'h0);

    // Backpressure: src=2 held, then 3, then idle.
    tick(16'h000C, 1'b0);
    tick(16'h0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(16'h0000, 1'b0);
      chk("bp_hold_src", 32'(src), 32'h2);
      chk("bp_hold_vld", 32'(valid), 32'h1);
    end
    tick(16'h0000, 1'b1);
    chk("bp_src3", 32'(src), 32'h3);
    tick(16'h0000, 1'b1);
    chk("bp_drain", 32'(valid), 32'h0);

    // Duplicate request on a pending source while stalled.
    tick(16'h00C0, 1'b0);
    tick(16'h0000, 1'b0);
    chk("dup_src6", 32'(src), 32'h6);
    tick(16'h0080, 1'b0);
    chk("dup_ovf1", 32'(overflow), 32'h1);
    chk("dup_pend", 32'(pending), 32'h0080);
    tick(16'h0000, 1'b0);
    chk("dup_ovf0", 32'(overflow), 32'h0);
    tick(16'h0000, 1'b1);
    chk("dup_src7", 32'(src), 32'h7);
    tick(16'h0000, 1'b1);
    chk("dup_once", 32'(valid), 32'h0);

    // Same-cycle re-request of the bit being taken.
    tick(16'h0010, 1'b1);
    tick(16'h0010, 1'b1);
    chk("rereq_src", 32'(src), 32'h4);
    chk("rereq_pend", 32'(pending), 32'h0010);
    chk("rereq_ovf", 32'(overflow), 32'h0);
    tick(16'h0000, 1'b1);
    chk("rereq_src2", 32'(src), 32'h4);
    chk("rereq_vld2", 32'(valid), 32'h1);
    tick(16'h0000, 1'b1);

    // Reset while full and holding a grant.
    tick(16'hFFFF, 1'b0);
    tick(16'hFFFF, 1'b0);
    chk("full_pend", 32'(pending), 32'hFFFF);
    chk("full_vld", 32'(valid), 32'h1);
    do_reset();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] rq;
      rq = '0;
      case ($urandom_range(0, 3))
        0: rq = '0;
        1: rq[$urandom_range(0, 15)] = 1'b1;
        2: rq = 16'($urandom) & 16'($urandom);
        default: rq = 16'($urandom);
      endcase
      tick(rq, ($urandom_range(0, 9) < 7));
    end
    for (int c = 0; c < 40; c++) tick(16'h0, 1'b1);
    chk("final_pend", 32'(pending), 32'h0);
    chk("final_vld", 32'(valid), 32'h0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dest_encoder.md
# dest_encoder

- Reverse of the destination decoder: collects one-hot request pulses from up to 16 sources and encodes them, one at a time, into a 4-bit source index.
- Requests are held pending until granted. Grants are issued round-robin over a registered valid/ready output.
- Sits between the 16 functional-unit writeback requesters and the register-file write port, which consumes the index.

## Interface

Parameters:
- N, 16, number of request lines.
- W, 4, index width; must equal clog2(N).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req  input  N  request pulses; bit i high for one cycle = one request from source i.
- src  output  W  encoded index of the granted source; valid only while valid=1.
- valid  output  1  src holds a grant.
- ready  input  1  consumer accepts src in any cycle where valid=1 and ready=1.
- pending  output  N  registered set of requests not yet granted.
- overflow  output  1  one-cycle pulse: a req bit arrived while that source was already pending; the duplicate is dropped.

## Operation

- Pending register update: pending_next = (pending & ~take) | req.
  - take is the one-hot of the index loaded this cycle, or 0 if nothing is loaded.
  - A req on the bit being taken in the same cycle stays pending; it is not lost and not flagged.
- overflow_next = |(req & pending & ~take).
- Output stage load condition: (valid==0 or ready==1) and pending != 0.
  - On load, select the first set bit of pending, searching upward from ptr with wrap 15 -> 0.
  - src <= that index; valid <= 1; take = onehot(index); ptr <= index+1 mod N (wrap 15 -> 0).
- Output stage drain: if valid and ready and pending == 0, then valid <= 0. src holds its last value.
- When valid=1 and ready=0, src, valid and ptr hold, and no take occurs. New requests still accumulate in pending.
- Selection considers only registered pending, never same-cycle req.
- Fairness: a continuously pending source is granted within N grants.

## Timing

- Reset (asynchronous assert, synchronous-safe deassert handled upstream) clears pending, overflow, valid and ptr, and sets src to 0.
- Reset mid-operation drops all pending requests and any held grant immediately.
- Latency: req pulse at cycle t -> pending bit set after edge t+1 -> valid=1 with src after edge t+2, if the output stage is empty or being accepted.
- Throughput: one grant per cycle while ready=1 and pending != 0.
- Back-to-back accept: valid stays high and src changes on the same edge as the accept.
- overflow asserts one cycle after the offending req. It is never sticky.
- All outputs are registered; there is no combinational path from req or ready to any output.

## Structure

- Shared package `dest_pkg`:
  - constants N_SRC=16 and IDX_W=4.
  - typedefs src_idx_t (logic [IDX_W-1:0]) and src_vec_t (logic [N_SRC-1:0]).
  - These are shared with the destination decoder.
- Sub-module `rr_pick`:
  - purely combinational round-robin priority encoder.
  - inputs: vector and ptr. outputs: any, index, onehot.
  - Implemented by rotate by ptr, then lowest-set-bit, then un-rotate.
- Top level holds the pending, output and ptr registers, plus the handshake logic.

## Test plan

- Single request: reset, req=16'h0020 for 1 cycle, ready=1 -> valid rises 2 cycles later with src=5 for exactly 1 cycle; pending returns to 0.
- Round-robin wrap: ptr=0, pending 16'h8001 granted, then src=0 is accepted; req bit 0 again -> next grants are 15, then 0. Source 15 must not be starved.
- Backpressure: ready=0, req=16'h000C -> src=2 is held stable with valid=1 for all stalled cycles. Raise ready -> src=2, then 3 on consecutive cycles, then valid=0.
- Duplicate request: bit 7 already pending with ready=0, req=16'h0080 again -> overflow pulses 1 cycle later for 1 cycle; only one grant of src=7 follows.
- Same-cycle re-request: req bit 4 asserted in the cycle 4 is taken -> bit 4 remains pending, overflow=0, second grant src=4 follows.
- Reset mid-operation: pending=16'hFFFF, valid=1; assert rst_n=0 asynchronously -> pending, valid, overflow and src become 0 without a clock edge.
